// File: rtl/dds_cmd_parser.sv
// dds_cmd_parser: frames, checksums and decodes UART command bytes, then
// commits frequency, phase and mode words to the DDS holding registers.
module dds_cmd_parser #(
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter logic [7:0]  HEADER         = 8'hAA
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [7:0]  Rx_Data,
  input  logic        Rx_Done,
  output logic [1:0]  Mode_Sel,
  output logic [31:0] Fword,
  output logic [11:0] Pword,
  output logic        Cmd_Valid,
  output logic        Cmd_Err,
  output logic [1:0]  Err_Code
);

  localparam int unsigned    TW     = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0]  T_LAST = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CMD  = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_CHK  = 2'd3;

  localparam logic [7:0] CMD_FREQ  = 8'h01;
  localparam logic [7:0] CMD_PHASE = 8'h02;
  localparam logic [7:0] CMD_MODE  = 8'h03;

  logic [1:0]    state_q;
  logic [7:0]    cmd_q;
  logic [7:0]    sum_q;
  logic [1:0]    cnt_q;
  logic [31:0]   shadow_q;
  logic [TW-1:0] tcnt_q;
  logic          timeout;

  // A strobe in the terminal count cycle takes priority over the timeout
  assign timeout = (state_q != S_IDLE) && !Rx_Done && (tcnt_q == T_LAST);

  // Inter-byte timer: runs only inside a frame, restarts on every byte
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      tcnt_q <= '0;
    end else if (Rx_Done || (state_q == S_IDLE) || timeout) begin
      tcnt_q <= '0;
    end else begin
      tcnt_q <= tcnt_q + TW'(1);
    end
  end

  // Frame state machine with command latch, running sum and payload shadow
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= S_IDLE;
      cmd_q    <= '0;
      sum_q    <= '0;
      cnt_q    <= '0;
      shadow_q <= '0;
    end else if (timeout) begin
      state_q <= S_IDLE;
    end else if (Rx_Done) begin
      case (state_q)
        S_IDLE: begin
          if (Rx_Data == HEADER) state_q <= S_CMD;
        end
        S_CMD: begin
          cmd_q   <= Rx_Data;
          sum_q   <= Rx_Data;
          cnt_q   <= '0;
          state_q <= S_DATA;
        end
        S_DATA: begin
          shadow_q <= {shadow_q[23:0], Rx_Data};
          sum_q    <= sum_q + Rx_Data;
          cnt_q    <= cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_q <= S_CHK;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Commit or reject on the checksum byte; outputs move only here
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      Mode_Sel  <= '0;
      Fword     <= '0;
      Pword     <= '0;
      Cmd_Valid <= 1'b0;
      Cmd_Err   <= 1'b0;
      Err_Code  <= '0;
    end else begin
      Cmd_Valid <= 1'b0;
      Cmd_Err   <= 1'b0;
      if (timeout) begin
        Cmd_Err  <= 1'b1;
        Err_Code <= 2'd3;
      end else if ((state_q == S_CHK) && Rx_Done) begin
        if (Rx_Data != sum_q) begin
          Cmd_Err  <= 1'b1;
          Err_Code <= 2'd1;
        end else begin
          case (cmd_q)
            CMD_FREQ: begin
              Fword     <= shadow_q;
              Cmd_Valid <= 1'b1;
            end
            CMD_PHASE: begin
              Pword     <= shadow_q[11:0];
              Cmd_Valid <= 1'b1;
            end
            CMD_MODE: begin
              Mode_Sel  <= shadow_q[1:0];
              Cmd_Valid <= 1'b1;
            end
            default: begin
              Cmd_Err  <= 1'b1;
              Err_Code <= 2'd2;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_dds_cmd_parser.sv
// tb_dds_cmd_parser: byte-level reference model and event scoreboard for
// the DDS command parser, with directed and randomized frame streams.
module tb_dds_cmd_parser;

  localparam int unsigned T   = 16;
  localparam logic [7:0]  HDR = 8'hAA;

  logic        Clk;
  logic        Reset_n;
  logic [7:0]  Rx_Data;
  logic        Rx_Done;
  logic [1:0]  Mode_Sel;
  logic [31:0] Fword;
  logic [11:0] Pword;
  logic        Cmd_Valid;
  logic        Cmd_Err;
  logic [1:0]  Err_Code;

  int unsigned tests = 0;
  int unsigned fails = 0;

  dds_cmd_parser #(.TIMEOUT_CYCLES(T), .HEADER(HDR)) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .Rx_Data   (Rx_Data),
    .Rx_Done   (Rx_Done),
    .Mode_Sel  (Mode_Sel),
    .Fword     (Fword),
    .Pword     (Pword),
    .Cmd_Valid (Cmd_Valid),
    .Cmd_Err   (Cmd_Err),
    .Err_Code  (Err_Code)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Events are encoded as cycle*4 + kind (kind 0 = commit, 1..3 = error code)
  int unsigned mcyc = 0;
  int unsigned obs_q[$];
  int unsigned exp_q[$];

  // Output monitor, sampling 1 time unit after each rising edge
  always @(posedge Clk) begin
    #1;
    mcyc++;
    if (Cmd_Valid) obs_q.push_back(mcyc * 4);
    if (Cmd_Err)   obs_q.push_back(mcyc * 4 + int'(Err_Code));
  end

  // Reference model: bytes collected into a frame list, evaluated when 7 are in
  logic [7:0]  fq[$];
  int unsigned idle_cnt;
  logic [31:0] m_f;
  logic [11:0] m_p;
  logic [1:0]  m_m;
  logic [1:0]  m_code;

  function automatic void model_reset();
    fq.delete();
    idle_cnt = 0;
    m_f = 0; m_p = 0; m_m = 0; m_code = 0;
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    int unsigned tot;
    idle_cnt = 0;
    if (fq.size() == 0) begin
      if (b == HDR) fq.push_back(b);
    end else begin
      fq.push_back(b);
      if (fq.size() == 7) begin
        tot = 0;
        for (int i = 1; i <= 5; i++) tot += int'(fq[i]);
        if ((tot % 256) != int'(fq[6])) begin
          m_code = 1; exp_q.push_back(mcyc * 4 + 1);
        end else if (fq[1] == 8'h01) begin
          m_f = {fq[2], fq[3], fq[4], fq[5]}; exp_q.push_back(mcyc * 4);
        end else if (fq[1] == 8'h02) begin
          m_p = {fq[4][3:0], fq[5]}; exp_q.push_back(mcyc * 4);
        end else if (fq[1] == 8'h03) begin
          m_m = fq[5][1:0]; exp_q.push_back(mcyc * 4);
        end else begin
          m_code = 2; exp_q.push_back(mcyc * 4 + 2);
        end
        fq.delete();
      end
    end
  endfunction

  function automatic void model_idle();
    if (fq.size() != 0) begin
      idle_cnt++;
      if (idle_cnt == T) begin
        m_code = 3; exp_q.push_back(mcyc * 4 + 3);
        fq.delete();
        idle_cnt = 0;
      end
    end
  endfunction

  // Drivers: every call starts and ends 2 time units after a rising edge
  task automatic send(input logic [7:0] b);
    Rx_Data = b;
    Rx_Done = 1'b1;
    @(posedge Clk);
    #2;
    Rx_Done = 1'b0;
    model_byte(b);
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) begin
      @(posedge Clk);
      #2;
      model_idle();
    end
  endtask

  task automatic send_seq(input logic [7:0] s[], input int unsigned n);
    for (int unsigned i = 0; i < n; i++) send(s[i]);
  endtask

  task automatic test_reset();
    logic [7:0] s[];
    Reset_n = 1'b0;
    idle(3);
    tests++; if ({Fword, Pword, Mode_Sel, Cmd_Valid, Cmd_Err, Err_Code} !== 50'd0) begin
      fails++; $display("FAIL reset_init: got F=%h P=%h M=%h V=%b E=%b C=%0d want all zero",
        Fword, Pword, Mode_Sel, Cmd_Valid, Cmd_Err, Err_Code);
    end
    Reset_n = 1'b1;
    model_reset();
    s = '{8'hAA, 8'h03, 8'h00, 8'h00, 8'h00, 8'h03, 8'h06,
          8'hAA, 8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFD,
          8'hAA, 8'h02, 8'h00, 8'h00, 8'h0F, 8'hFF, 8'h10,
          8'hAA, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h05,
          8'hAA, 8'h01, 8'h12, 8'h34};
    send_seq(s, 32);
    Reset_n = 1'b0;
    #1;
    tests++; if ({Fword, Pword, Mode_Sel, Cmd_Valid, Cmd_Err, Err_Code} !== 50'd0) begin
      fails++; $display("FAIL reset_mid_frame: got F=%h P=%h M=%h V=%b E=%b C=%0d want all zero",
        Fword, Pword, Mode_Sel, Cmd_Valid, Cmd_Err, Err_Code);
    end
    @(posedge Clk); #2;
    Reset_n = 1'b1;
    model_reset();
    obs_q.delete(); exp_q.delete();
    s = '{8'hAA, 8'h01, 8'h00, 8'h10, 8'h00, 8'h00, 8'h11};
    send_seq(s, 7);
    tests++; if (obs_q.size() != 1 || obs_q[0] !== mcyc * 4) begin
      fails++; $display("FAIL reset_then_commit: %0d events, first code %0d, want 1 commit at cycle %0d",
        obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 0, mcyc);
    end
    idle(1);
    tests++; if (Fword !== 32'h0010_0000) begin
      fails++; $display("FAIL reset_fword: got %h want 00100000", Fword);
    end
  endtask

  task automatic test_pword_mode();
    logic [7:0] s[];
    obs_q.delete(); exp_q.delete();
    s = '{8'hAA, 8'h02, 8'h00, 8'h00, 8'hF4, 8'h00, 8'hF6,
          8'hAA, 8'h03, 8'h00, 8'h00, 8'h00, 8'h02, 8'h05};
    send_seq(s, 14);
    idle(2);
    tests++; if (Pword !== 12'h400) begin
      fails++; $display("FAIL pword: got %h want 400", Pword);
    end
    tests++; if (Mode_Sel !== 2'b10) begin
      fails++; $display("FAIL mode: got %b want 10", Mode_Sel);
    end
    tests++; if (Fword !== 32'h0010_0000) begin
      fails++; $display("FAIL pword_mode_fword_kept: got %h want 00100000", Fword);
    end
    tests++; if (obs_q.size() != exp_q.size()) begin
      fails++; $display("FAIL pword_mode_events: got %0d events want %0d", obs_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      tests++; if (obs_q[i] !== exp_q[i]) begin
        fails++; $display("FAIL pword_mode_event[%0d]: got cyc %0d kind %0d want cyc %0d kind %0d",
          i, obs_q[i] / 4, obs_q[i] % 4, exp_q[i] / 4, exp_q[i] % 4);
      end
    end
  endtask

  task automatic test_reject();
    logic [7:0] s[];
    obs_q.delete(); exp_q.delete();
    s = '{8'hAA, 8'h01, 8'h00, 8'h10, 8'h00, 8'h00, 8'h12};
    send_seq(s, 7);
    idle(1);
    tests++; if (obs_q.size() != 1 || obs_q[0] !== (mcyc - 1) * 4 + 1) begin
      fails++; $display("FAIL reject_csum: %0d events, first %0d, want one code-1 error at cycle %0d",
        obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 0, mcyc - 1);
    end
    tests++; if (Err_Code !== 2'd1 || Fword !== 32'h0010_0000) begin
      fails++; $display("FAIL reject_csum_regs: got code %0d F=%h want 1 00100000", Err_Code, Fword);
    end
    s = '{8'hAA, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h04};
    send_seq(s, 7);
    idle(3);
    tests++; if (Err_Code !== 2'd2) begin
      fails++; $display("FAIL reject_unknown: got code %0d want 2", Err_Code);
    end
    s = '{8'hAA, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h05};
    send_seq(s, 7);
    idle(1);
    tests++; if (Err_Code !== 2'd1) begin
      fails++; $display("FAIL reject_precedence: got code %0d want 1", Err_Code);
    end
    tests++; if ({Fword, Pword, Mode_Sel} !== {m_f, m_p, m_m}) begin
      fails++; $display("FAIL reject_regs_kept: got F=%h P=%h M=%b want F=%h P=%h M=%b",
        Fword, Pword, Mode_Sel, m_f, m_p, m_m);
    end
    tests++; if (obs_q.size() != exp_q.size()) begin
      fails++; $display("FAIL reject_events: got %0d events want %0d", obs_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      tests++; if (obs_q[i] !== exp_q[i]) begin
        fails++; $display("FAIL reject_event[%0d]: got cyc %0d kind %0d want cyc %0d kind %0d",
          i, obs_q[i] / 4, obs_q[i] % 4, exp_q[i] / 4, exp_q[i] % 4);
      end
    end
  endtask

  task automatic test_timeout();
    logic [7:0] s[];
    int unsigned s0;
    obs_q.delete(); exp_q.delete();
    s = '{8'hAA, 8'h01, 8'h00};
    send_seq(s, 3);
    s0 = mcyc;
    idle(20);
    tests++; if (obs_q.size() != 1 || obs_q[0] !== (s0 + T) * 4 + 3) begin
      fails++; $display("FAIL timeout_pulse: %0d events, first cyc %0d kind %0d, want code 3 at cyc %0d",
        obs_q.size(), (obs_q.size() > 0) ? obs_q[0] / 4 : 0, (obs_q.size() > 0) ? obs_q[0] % 4 : 0, s0 + T);
    end
    tests++; if (Err_Code !== 2'd3) begin
      fails++; $display("FAIL timeout_code: got %0d want 3", Err_Code);
    end
    s = '{8'hAA, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h39};
    send_seq(s, 7);
    idle(1);
    tests++; if (Fword !== 32'hDEAD_BEEF) begin
      fails++; $display("FAIL timeout_recover: got %h want deadbeef", Fword);
    end
    obs_q.delete(); exp_q.delete();
    s = '{8'hAA, 8'h01, 8'hAA};
    send_seq(s, 3);
    idle(T - 1);
    s = '{8'h00, 8'h00, 8'h01, 8'hAC};
    send_seq(s, 4);
    idle(1);
    tests++; if (Fword !== 32'hAA00_0001 || obs_q.size() != 1 || obs_q[0] % 4 != 0) begin
      fails++; $display("FAIL timeout_boundary: got F=%h with %0d events, want aa000001 with 1 commit",
        Fword, obs_q.size());
    end
    tests++; if (obs_q.size() != exp_q.size()) begin
      fails++; $display("FAIL timeout_events: got %0d events want %0d", obs_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      tests++; if (obs_q[i] !== exp_q[i]) begin
        fails++; $display("FAIL timeout_event[%0d]: got cyc %0d kind %0d want cyc %0d kind %0d",
          i, obs_q[i] / 4, obs_q[i] % 4, exp_q[i] / 4, exp_q[i] % 4);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] s[];
    obs_q.delete(); exp_q.delete();
    s = '{8'h12, 8'h55,
          8'hAA, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h15,
          8'hAA, 8'h02, 8'h00, 8'h00, 8'h0A, 8'hBC, 8'hC8};
    send_seq(s, 16);
    idle(1);
    tests++; if (obs_q.size() != 2 || (obs_q[1] - obs_q[0]) !== 28 || obs_q[0] % 4 != 0) begin
      fails++; $display("FAIL back_to_back: got %0d events, want 2 commits 7 cycles apart", obs_q.size());
    end
    tests++; if (Fword !== 32'h1234_5678 || Pword !== 12'hABC) begin
      fails++; $display("FAIL back_to_back_regs: got F=%h P=%h want 12345678 abc", Fword, Pword);
    end
    tests++; if (obs_q.size() != exp_q.size()) begin
      fails++; $display("FAIL b2b_events: got %0d events want %0d", obs_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      tests++; if (obs_q[i] !== exp_q[i]) begin
        fails++; $display("FAIL b2b_event[%0d]: got cyc %0d kind %0d want cyc %0d kind %0d",
          i, obs_q[i] / 4, obs_q[i] % 4, exp_q[i] / 4, exp_q[i] % 4);
      end
    end
  endtask

  function automatic int unsigned pick_gap();
    int unsigned r;
    r = $urandom_range(0, 19);
    if (r < 12) return 0;
    if (r < 18) return $urandom_range(1, 4);
    if (r == 18) return T - 1;
    return T;
  endfunction

  task automatic test_random();
    logic [7:0]  f[7];
    logic [7:0]  g;
    int unsigned r, trunc;
    obs_q.delete(); exp_q.delete();
    repeat (60) begin
      repeat ($urandom_range(0, 2)) begin
        g = 8'($urandom_range(0, 255));
        if (g == HDR) g = 8'h55;
        idle(pick_gap());
        send(g);
      end
      r = $urandom_range(0, 9);
      f[0] = HDR;
      f[1] = (r < 3) ? 8'h01 : (r < 6) ? 8'h02 : (r < 8) ? 8'h03 : 8'($urandom_range(0, 255));
      for (int i = 2; i <= 5; i++) f[i] = 8'($urandom_range(0, 255));
      f[6] = f[1] + f[2] + f[3] + f[4] + f[5];
      if ($urandom_range(0, 4) == 0) f[6] = f[6] ^ 8'($urandom_range(1, 255));
      trunc = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 6) : 7;
      for (int unsigned i = 0; i < trunc; i++) begin
        if (i > 0) idle(pick_gap());
        send(f[i]);
      end
      if (trunc < 7) idle(T + $urandom_range(0, 4));
    end
    idle(T + 4);
    tests++; if ({Fword, Pword, Mode_Sel, Err_Code} !== {m_f, m_p, m_m, m_code}) begin
      fails++; $display("FAIL random_regs: got F=%h P=%h M=%b C=%0d want F=%h P=%h M=%b C=%0d",
        Fword, Pword, Mode_Sel, Err_Code, m_f, m_p, m_m, m_code);
    end
    tests++; if (obs_q.size() != exp_q.size()) begin
      fails++; $display("FAIL random_events: got %0d events want %0d", obs_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      tests++; if (obs_q[i] !== exp_q[i]) begin
        fails++; $display("FAIL random_event[%0d]: got cyc %0d kind %0d want cyc %0d kind %0d",
          i, obs_q[i] / 4, obs_q[i] % 4, exp_q[i] / 4, exp_q[i] % 4);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    Reset_n = 1'b0;
    Rx_Done = 1'b0;
    Rx_Data = 8'h00;
    model_reset();
    @(posedge Clk);
    #2;
    test_reset();
    test_pword_mode();
    test_reject();
    test_timeout();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dds_cmd_parser.md
# dds_cmd_parser

Byte-stream command parser that sits directly upstream of the DDS waveform generator. It takes received bytes from the UART receiver, frames and checksums them, and drives the generator's mode, frequency word and phase word from holding registers. Each holding register updates atomically only after a complete, valid frame, so the DDS never sees a half-written word.

## Interface
- TIMEOUT_CYCLES, 50000: maximum clock cycles allowed between bytes inside a frame (1 ms at 50 MHz); minimum 2.
- HEADER, 8'hAA: frame start byte.
- Clk  input  1  system clock.
- Reset_n  input  1  reset, asynchronous, active-low.
- Rx_Data  input  8  received byte; valid only in the cycle Rx_Done is high.
- Rx_Done  input  1  single-cycle strobe, one per received byte.
- Mode_Sel  output  2  waveform mode to DDS; reset 2'b00.
- Fword  output  32  frequency word to DDS; reset 32'd0.
- Pword  output  12  phase word to DDS; reset 12'd0.
- Cmd_Valid  output  1  one-cycle pulse when a frame is committed; reset 0.
- Cmd_Err  output  1  one-cycle pulse when a frame is rejected; reset 0.
- Err_Code  output  2  reason for the last rejection; holds until the next rejection; reset 2'd0.
  - 1 = bad checksum.
  - 2 = unknown command.
  - 3 = timeout.

## Operation
- Frame format: HEADER, CMD, D3, D2, D1, D0, CSUM (7 bytes, payload big-endian).
- CSUM = (CMD + D3 + D2 + D1 + D0) mod 256, computed as an 8-bit running sum.
- Commands:
  - 8'h01: Fword <= {D3,D2,D1,D0}.
  - 8'h02: Pword <= {D1[3:0],D0}; the remaining payload bits are ignored.
  - 8'h03: Mode_Sel <= D0[1:0]; the remaining payload bits are ignored.
  - Any other CMD is unknown.
- State machine:
  - IDLE: a byte equal to HEADER moves to CMD. Any other byte is discarded silently, with no error.
  - CMD: latch CMD, initialise the sum to CMD, clear the byte counter, move to DATA.
  - DATA: shift the byte into a 32-bit shadow register and add it to the sum. After the 4th byte (counter == 3), move to CHK.
  - CHK: on the byte, compare it with the sum and always return to IDLE.
    - Mismatch: reject, code 1.
    - Match and unknown CMD: reject, code 2.
    - Match and known CMD: commit the shadow value to the selected register and pulse Cmd_Valid.
- Checksum failure takes precedence over an unknown command.
- A HEADER byte arriving in CMD, DATA or CHK is treated as ordinary data, not as a resync.
- Timeout counter:
  - Clears on every Rx_Done and is held at 0 in IDLE.
  - Increments every cycle in any non-IDLE state.
  - When it reaches TIMEOUT_CYCLES-1 with no Rx_Done in that cycle, the parser returns to IDLE and rejects the frame with code 3.
- Output registers change only on commit. Shadow and partial state never reach the outputs.
- Rejection leaves Mode_Sel, Fword and Pword unchanged.
- Reset mid-frame: all state returns to IDLE and all outputs return to their reset values immediately (asynchronous).

## Timing
- Rx_Done is sampled on the rising edge of Clk. One byte is consumed per strobe.
- Back-to-back strobes on consecutive cycles must be accepted.
- Commit latency: the selected output register, Cmd_Valid and (on rejection) Cmd_Err/Err_Code are all registered on the first edge after the CHK-byte strobe cycle, so they are visible 1 cycle after the strobe.
- Cmd_Valid and Cmd_Err are mutually exclusive and each is high for exactly 1 cycle.
- A new HEADER may arrive in the cycle immediately after the CHK byte; the parser is in IDLE by then.
- Timeout pulse: Cmd_Err rises 1 cycle after the terminal count cycle.
- An Rx_Done in the terminal count cycle wins: the byte is consumed and no timeout is raised.
- No output-enable or ready handshake exists. The downstream DDS re-registers all outputs, adding 1 more cycle there.

## Test plan
- Reset: assert Reset_n=0 mid-DATA -> Fword=0, Pword=0, Mode_Sel=0, Cmd_Valid=0, Cmd_Err=0, Err_Code=0. Then send AA 01 00 10 00 00 11 -> Fword=32'h00100000, with Cmd_Valid pulsing 1 cycle after the last strobe.
- Pword and mode commands:
  - AA 02 00 00 F4 00 F6 -> Pword=12'h400 (upper nibble ignored).
  - AA 03 00 00 00 02 05 -> Mode_Sel=2'b10.
  - Neither frame disturbs the other registers.
- Rejections:
  - AA 01 00 10 00 00 12 -> Cmd_Err pulse, Err_Code=1, Fword unchanged.
  - AA 04 00 00 00 00 04 -> Err_Code=2.
  - AA 04 00 00 00 00 05 -> Err_Code=1.
- Timeout: with TIMEOUT_CYCLES=16, send AA 01 00 then stall 20 cycles -> Cmd_Err at the cycle after count 15, Err_Code=3, state IDLE. Then send a full valid frame -> commits normally.
- Timeout boundary: a byte strobe exactly at count 15 -> no timeout and the frame continues.
- Resync and streaming:
  - Garbage bytes 12 55 before AA -> ignored, no error.
  - Two valid frames with Rx_Done on consecutive cycles and no gap -> both commit, giving two Cmd_Valid pulses 7 cycles apart.
